// File: rtl/small_fallthrough_fifo.sv
// First-word-fall-through FIFO: a write appears on dout one edge later, and dout is read combinationally from the head slot.
// There is no backpressure. Writes while full are dropped, reads while empty are ignored, and nearly_full leaves one slot of slack upstream.
module small_fallthrough_fifo #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = (1 << MAX_DEPTH_BITS) - 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0]   CNT_FULL  = (MAX_DEPTH_BITS+1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_NEAR  = (MAX_DEPTH_BITS+1)'(DEPTH - 1);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_PROG  = (MAX_DEPTH_BITS+1)'(PROG_FULL_THRESHOLD);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE   = (MAX_DEPTH_BITS+1)'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = MAX_DEPTH_BITS'(1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      wr_acc;
  logic                      rd_acc;

  // Flags come only from the registered count, so an async reset clears them at once.
  assign empty       = (count == '0);
  assign full        = (count == CNT_FULL);
  assign nearly_full = (count >= CNT_NEAR);
  assign prog_full   = (count >= CNT_PROG);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_small_fallthrough_fifo.sv
// Bench for small_fallthrough_fifo (WIDTH=8, DEPTH=4). Directed scenarios are followed by random traffic.
// A queue-based reference model is compared on every falling edge against the flags and the head word.
module tb_small_fallthrough_fifo;

  localparam int W  = 8;
  localparam int DB = 2;
  localparam int D  = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] din = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] dout;
  logic         full, nearly_full, prog_full, empty;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] q[$];
  bit mon_en = 1'b0;

  small_fallthrough_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(DB), .PROG_FULL_THRESHOLD(D-1)) dut (
    .clk(clk), .resetn(resetn), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .nearly_full(nearly_full), .prog_full(prog_full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue with occupancy limit D.
  always @(posedge clk) begin
    if (resetn) begin
      bit wa, ra;
      wa = wr_en && (q.size() < D);
      ra = rd_en && (q.size() > 0);
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(din);
    end
  end

  always @(negedge resetn) q.delete();

  // Monitor: compare flags always, and the head word whenever the DUT presents one.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_empty", {31'b0, empty}, {31'b0, q.size() == 0});
      chk("mon_full", {31'b0, full}, {31'b0, q.size() == D});
      chk("mon_nearly_full", {31'b0, nearly_full}, {31'b0, q.size() >= D-1});
      chk("mon_prog_full", {31'b0, prog_full}, {31'b0, q.size() >= D-1});
      if (!empty && q.size() > 0) chk("mon_dout", {24'b0, dout}, {24'b0, q[0]});
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [W-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    // 1: reset held with a write strobe active
    wr_en = 1'b1;
    din = 8'hFF;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_rst_empty", {31'b0, empty}, 32'd1);
    chk("t1_rst_full", {31'b0, full}, 32'd0);
    chk("t1_rst_nfull", {31'b0, nearly_full}, 32'd0);
    wr_en = 1'b0;
    resetn = 1'b1;
    cyc(1, 0, 8'hA5);
    chk("t1_dout", {24'b0, dout}, 32'hA5);
    chk("t1_empty", {31'b0, empty}, 32'd0);
    cyc(0, 1, 0);
    chk("t1_drained", {31'b0, empty}, 32'd1);

    // 2: fill, overflow drop, drain
    cyc(1, 0, 8'h01);
    cyc(1, 0, 8'h02);
    chk("t2_nf_after2", {31'b0, nearly_full}, 32'd0);
    cyc(1, 0, 8'h03);
    chk("t2_nf_after3", {31'b0, nearly_full}, 32'd1);
    chk("t2_full_after3", {31'b0, full}, 32'd0);
    cyc(1, 0, 8'h04);
    chk("t2_full_after4", {31'b0, full}, 32'd1);
    chk("t2_prog_after4", {31'b0, prog_full}, 32'd1);
    cyc(1, 0, 8'h05);
    chk("t2_full_after_drop", {31'b0, full}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_pop", {24'b0, dout}, 32'(i));
      cyc(0, 1, 0);
    end
    chk("t2_empty", {31'b0, empty}, 32'd1);

    // 3: underflow
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("t3_empty", {31'b0, empty}, 32'd1);
    cyc(1, 0, 8'h10);
    chk("t3_dout", {24'b0, dout}, 32'h10);
    chk("t3_nf", {31'b0, nearly_full}, 32'd0);
    cyc(0, 1, 0);
    chk("t3_empty_again", {31'b0, empty}, 32'd1);

    // 4: simultaneous read/write with two words held, crossing the pointer wrap
    cyc(1, 0, 8'h20);
    cyc(1, 0, 8'h21);
    for (int i = 0; i < 6; i++) begin
      chk("t4_head", {24'b0, dout}, 32'h20 + 32'(i));
      cyc(1, 1, 8'h22 + 8'(i));
      chk("t4_nf", {31'b0, nearly_full}, 32'd0);
      chk("t4_not_empty", {31'b0, empty}, 32'd0);
    end
    chk("t4_tail0", {24'b0, dout}, 32'h26);
    cyc(0, 1, 0);
    chk("t4_tail1", {24'b0, dout}, 32'h27);
    cyc(0, 1, 0);
    chk("t4_empty", {31'b0, empty}, 32'd1);

    // 5: full with simultaneous read and write, so the write is dropped
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h30 + 8'(i));
    chk("t5_full", {31'b0, full}, 32'd1);
    cyc(1, 1, 8'h55);
    chk("t5_full_after", {31'b0, full}, 32'd0);
    chk("t5_nf_after", {31'b0, nearly_full}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk("t5_pop", {24'b0, dout}, 32'h30 + 32'(i));
      cyc(0, 1, 0);
    end
    chk("t5_empty", {31'b0, empty}, 32'd1);

    // 6: asynchronous reset between clock edges
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h40 + 8'(i));
    chk("t6_held", {31'b0, nearly_full}, 32'd1);
    resetn = 1'b0;
    #2;
    chk("t6_async_empty", {31'b0, empty}, 32'd1);
    chk("t6_async_nf", {31'b0, nearly_full}, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 0, 8'h50);
    cyc(1, 0, 8'h51);
    chk("t6_post0", {24'b0, dout}, 32'h50);
    cyc(0, 1, 0);
    chk("t6_post1", {24'b0, dout}, 32'h51);
    cyc(0, 1, 0);
    chk("t6_empty", {31'b0, empty}, 32'd1);

    // Random traffic, checked continuously by the monitor
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), 8'($urandom));
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
